// File: rtl/slice_subtractor_pkg.sv
// slice_subtractor_pkg
//   Shared definitions for the slice-serial subtractor: the FSM state type
//   and the width of one subtraction slice.
package slice_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned SLICE_W = 4;

endpackage

// File: rtl/slice_subtractor_sub4.sv
// bla_sub4
//   Combinational 4-bit subtract slice with borrow lookahead: d = x - y - bi.
//   Every internal borrow is formed directly from generate/propagate terms,
//   so nothing ripples bit-to-bit through the slice.
// Ports:
//   x  [3:0] in   minuend slice
//   y  [3:0] in   subtrahend slice
//   bi       in   borrow into bit 0
//   d  [3:0] out  difference slice
//   bo       out  borrow out of bit 3
module bla_sub4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1, c2, c3;

  // Bit i borrows when x_i=0, y_i=1; it passes an incoming borrow when x_i==y_i.
  assign g = ~x & y;
  assign p = ~(x ^ y);

  assign c1 = g[0] | (p[0] & bi);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & bi);
  assign bo = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d = x ^ y ^ {c3, c2, c1, bi};

endmodule

// File: rtl/slice_subtractor.sv
// slice_subtractor
//   Slice-serial unsigned subtractor: diff = a - b - bin (mod 2^WIDTH),
//   bout = borrow-out. Operands are captured in IDLE, one 4-bit slice is
//   processed per BUSY cycle (LSB first), and the result is held in DONE until
//   out_ready. Result latency from the accept edge is WIDTH/4 cycles.
// Configuration macro:
//   SLICE_SUBTRACTOR_OVF_EN  adds output ovf (two's-complement overflow).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand set presented
//   in_ready   out  operand set accepted this cycle (IDLE only)
//   a, b [W]   in   minuend, subtrahend (unsigned)
//   bin        in   borrow-in
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer takes the result
//   diff [W]   out  difference
//   bout       out  borrow-out
//   ovf        out  signed overflow (only with SLICE_SUBTRACTOR_OVF_EN)
module slice_subtractor
  import slice_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SLICE_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q, diff_q;
  logic               borrow_q, bout_q;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] x_s, y_s, d_s;
  logic               bo_s;
  logic               last;
  logic               accept;

  assign x_s    = a_q[idx*SLICE_W +: SLICE_W];
  assign y_s    = b_q[idx*SLICE_W +: SLICE_W];
  assign last   = (idx == IDX_W'(NSLICE - 1));
  assign accept = (state == IDLE) && in_valid;

  // Single slice instance, time-shared across BUSY cycles via idx.
  bla_sub4 u_slice (
    .x  (x_s),
    .y  (y_s),
    .bi (borrow_q),
    .d  (d_s),
    .bo (bo_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      borrow_q <= bin;
      idx      <= '0;
    end else if (state == BUSY) begin
      diff_q[idx*SLICE_W +: SLICE_W] <= d_s;
      borrow_q <= bo_s;
      idx      <= idx + 1'b1;
      if (last) bout_q <= bo_s;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

`ifdef SLICE_SUBTRACTOR_OVF_EN
  logic ovf_q;

  // The top slice's d_s[3] is the sign of diff, available on the last BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf_q <= 1'b0;
    else if (state == BUSY && last) ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                                           & (d_s[SLICE_W-1] ^ a_q[WIDTH-1]);
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_slice_subtractor.sv
module tb_slice_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, diff16;
  logic        bin16 = 1'b0, bout16;
  // 4-bit instance for the exhaustive sweep
  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, diff4;
  logic        bin4 = 1'b0, bout4;
`ifdef SLICE_SUBTRACTOR_OVF_EN
  logic        ovf16, ovf4;
`endif

  slice_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .bin(bin16), .out_valid(out_valid16),
    .out_ready(out_ready16), .diff(diff16), .bout(bout16)
`ifdef SLICE_SUBTRACTOR_OVF_EN
    , .ovf(ovf16)
`endif
  );

  slice_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4),
    .out_ready(out_ready4), .diff(diff4), .bout(bout4)
`ifdef SLICE_SUBTRACTOR_OVF_EN
    , .ovf(ovf4)
`endif
  );

  int tests  = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge while dut16 is IDLE; returns at the negedge after accept.
  task automatic apply16(input logic [15:0] a, input logic [15:0] b, input logic bin);
    in_valid16 = 1'b1;
    a16 = a; b16 = b; bin16 = bin;
    @(negedge clk);
    in_valid16 = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid (bounded).
  task automatic wait_done16(output int lat);
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume16();
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[8] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    vecs[9] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h1E1E, 1'b1, 1'b0};

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready16), 32'd1);
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_diff", 32'(diff16), 32'd0);
    check("rst_bout", 32'(bout16), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      check($sformatf("v%0d_in_ready", i), 32'(in_ready16), 32'd1);
      apply16(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done16(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_diff", i), 32'(diff16), 32'(vecs[i].diff));
      check($sformatf("v%0d_bout", i), 32'(bout16), 32'(vecs[i].bout));
`ifdef SLICE_SUBTRACTOR_OVF_EN
      check($sformatf("v%0d_ovf", i), 32'(ovf16), 32'(vecs[i].ovf));
`endif
      consume16();
    end

    // Backpressure: hold in DONE, concurrent in_valid must be ignored
    apply16(16'h1234, 16'h0234, 1'b0);
    wait_done16(lat);
    check("bp_latency", 32'(lat), 32'd4);
    in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; bin16 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", k), 32'(out_valid16), 32'd1);
      check($sformatf("bp%0d_in_ready", k), 32'(in_ready16), 32'd0);
      check($sformatf("bp%0d_diff", k), 32'(diff16), 32'h1000);
      check($sformatf("bp%0d_bout", k), 32'(bout16), 32'd0);
    end
    // Release with in_valid still high: consume edge must not also accept
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    in_valid16  = 1'b0;
    check("bp_release_out_valid", 32'(out_valid16), 32'd0);
    check("bp_release_in_ready", 32'(in_ready16), 32'd1);
    @(negedge clk);
    check("bp_idle_hold", 32'(in_ready16), 32'd1);

    // Reset during the 2nd BUSY cycle
    apply16(16'hFFFF, 16'h0001, 1'b0);   // now in 1st BUSY cycle
    @(negedge clk);                        // 2nd BUSY cycle
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid16), 32'd0);
    check("mid_rst_diff", 32'(diff16), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready16), 32'd1);
    check("mid_rst_bout", 32'(bout16), 32'd0);
    @(negedge clk);
    // Accept on the very first rising edge with rst=0
    rst = 1'b0;
    apply16(16'h0005, 16'h0003, 1'b0);
    check("post_rst_accepted", 32'(in_ready16), 32'd0);
    wait_done16(lat);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_diff", 32'(diff16), 32'h0002);
    check("post_rst_bout", 32'(bout16), 32'd0);
    consume16();

    // Exhaustive WIDTH=4, back-to-back with out_ready held high
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    for (int n = 0; n < 512; n++) begin
      logic [3:0] ea, eb, ed;
      logic       ebin, ebo, ok;
      logic [4:0] full;
      ea   = 4'(n >> 5);
      eb   = 4'(n >> 1);
      ebin = n[0];
      full = {1'b0, ea} - {1'b0, eb} - {4'b0, ebin};
      ed   = full[3:0];
      ebo  = full[4];
      ok   = in_ready4;
      a4 = ea; b4 = eb; bin4 = ebin;
      @(negedge clk);
      ok = ok & ~in_ready4 & ~out_valid4;
      @(negedge clk);
      ok = ok & out_valid4 & (diff4 == ed) & (bout4 == ebo);
`ifdef SLICE_SUBTRACTOR_OVF_EN
      ok = ok & (ovf4 == ((ea[3] ^ eb[3]) & (ed[3] ^ ea[3])));
`endif
      tests++;
      if (!ok) begin
        errors++;
        $display("FAIL exh4 a=%0h b=%0h bin=%0d: got diff=%0h bout=%0d valid=%0d expected diff=%0h bout=%0d",
                 ea, eb, ebin, diff4, bout4, out_valid4, ed, ebo);
      end
      @(negedge clk);
    end
    in_valid4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
